// File: rtl/par_to_serial_8b_if.sv
`default_nettype none
// ============================================================================
//  Module   : par_to_serial_8b_if
//  Purpose  : Parallel-word handshake and serial-line bundle for par_to_serial_8b.
//  Revision : 1.0 - initial release
// ============================================================================
interface par_to_serial_8b_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] data_in;
    logic             valid_in;
    logic             ready;
    logic             serial_out;
    logic             active_out;

    // Upstream word source plus serial-line observer.
    modport master (
        output data_in,
        output valid_in,
        input  ready,
        input  serial_out,
        input  active_out
    );

    // The converter itself.
    modport slave (
        input  data_in,
        input  valid_in,
        output ready,
        output serial_out,
        output active_out
    );
endinterface
`default_nettype wire

// File: rtl/par_to_serial_8b.sv
`default_nettype none
// ============================================================================
//  Module   : par_to_serial_8b
//  Purpose  : Parallel-to-serial converter, one WIDTH-bit word per byte-time,
//             MSB first. Optional macro IDLE_COMMA_EN sends IDLE_WORD when idle.
//  Revision : 1.0 - initial release
// ============================================================================
module par_to_serial_8b #(
    parameter int         WIDTH     = 8,
    parameter logic [7:0] IDLE_WORD = 8'hBC
) (
    input  wire logic          clk_32f,
    input  wire logic          reset,
    par_to_serial_8b_if.slave  bus
);

    localparam int                   c_cnt_w = $clog2(WIDTH);
    localparam logic [c_cnt_w-1:0]   c_last  = c_cnt_w'(WIDTH - 1);

`ifdef IDLE_COMMA_EN
    localparam logic                 c_comma_en = 1'b1;
`else
    localparam logic                 c_comma_en = 1'b0;
`endif

    // Widen before slicing so WIDTH below 8 truncates and above 8 zero-fills.
    localparam logic [23:0]          c_idle_ext  = {16'h0000, IDLE_WORD};
    localparam logic [WIDTH-1:0]     c_idle_word = c_comma_en ? c_idle_ext[WIDTH-1:0] : '0;

    generate
        if (WIDTH < 2 || WIDTH > 16) begin : g_width_bad
            $error("par_to_serial_8b: WIDTH must be within 2..16");
        end
    endgenerate

    logic [c_cnt_w-1:0] r_cnt;
    logic [WIDTH-1:0]   r_shreg;
    logic               r_act;
    logic               w_load;

    assign w_load = (r_cnt == c_last);

    // The counter resets to the load phase so the first active cycle accepts a word.
    always_ff @(posedge clk_32f) begin
        if (!reset) begin
            r_cnt   <= c_last;
            r_shreg <= '0;
            r_act   <= 1'b0;
        end else if (w_load) begin
            r_cnt <= '0;
            if (bus.valid_in) begin
                r_shreg <= bus.data_in;
                r_act   <= 1'b1;
            end else begin
                r_shreg <= c_idle_word;
                r_act   <= 1'b0;
            end
        end else begin
            r_cnt   <= r_cnt + 1'b1;
            r_shreg <= {r_shreg[WIDTH-2:0], 1'b0};
        end
    end

    assign bus.ready      = w_load && reset;
    assign bus.serial_out = r_shreg[WIDTH-1];
    assign bus.active_out = r_act;

endmodule
`default_nettype wire

// File: tb/tb_par_to_serial_8b.sv
`default_nettype none
// ============================================================================
//  Module   : tb_par_to_serial_8b
//  Purpose  : Scoreboard bench for par_to_serial_8b with directed word vectors.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_par_to_serial_8b;

`ifdef IDLE_COMMA_EN
    localparam logic [7:0] c_idle_pat = 8'b1011_1100;
`else
    localparam logic [7:0] c_idle_pat = 8'b0000_0000;
`endif

    localparam int c_timeout_ns = 100000;

    logic clk;
    logic reset;

    par_to_serial_8b_if #(.WIDTH(8)) bus ();

    par_to_serial_8b #(
        .WIDTH     (8),
        .IDLE_WORD (8'hBC)
    ) dut (
        .clk_32f (clk),
        .reset   (reset),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected {ready, serial_out, active_out} per cycle, and the bit stream still owed.
    logic [2:0] exp_q [$];
    logic [1:0] pend  [$];
    int         vectors = 0;
    int         misc    = 0;
    int         cyc     = 0;

    always @(negedge clk) begin
        logic [2:0] e;
        logic [2:0] got;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            got = {bus.ready, bus.serial_out, bus.active_out};
            vectors++;
            if (got !== e) begin
                misc++;
                $display("FAIL cycle%0d ready/serial/active: got %b%b%b, want %b%b%b",
                         cyc, got[2], got[1], got[0], e[2], e[1], e[0]);
            end
            cyc++;
        end
    end

    task automatic tick(input logic rst_n, input logic v, input logic [7:0] d, input logic rdy);
        logic [1:0] sa;
        @(posedge clk);
        #1;
        reset        = rst_n;
        bus.valid_in = v;
        bus.data_in  = d;
        sa = 2'b00;
        if (pend.size() > 0) sa = pend.pop_front();
        if (!rst_n) pend.delete();
        exp_q.push_back({rdy, sa});
    endtask

    task automatic offer(input logic [7:0] pat, input logic a);
        for (int i = 7; i >= 0; i--) pend.push_back({pat[i], a});
    endtask

    // One byte-time: load cycle with (v,d), then 7 shift cycles driving a decoy.
    task automatic slot(input logic v, input logic [7:0] d, input logic [7:0] pat,
                        input logic a, input logic dv, input logic [7:0] dd);
        tick(1'b1, v, d, 1'b1);
        offer(pat, a);
        for (int i = 0; i < 7; i++) tick(1'b1, dv, dd, 1'b0);
    endtask

    initial begin
        #(c_timeout_ns);
        misc++;
        $display("FAIL timeout: stimulus did not finish within %0d ns", c_timeout_ns);
        $finish;
    end

    initial begin
        reset        = 1'b0;
        bus.valid_in = 1'b0;
        bus.data_in  = 8'h00;

        for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 8'h00, 1'b0);

        vectors++;
        if ({bus.ready, bus.serial_out, bus.active_out} !== 3'b000) begin
            misc++;
            $display("FAIL reset state ready/serial/active: got %b%b%b, want 000",
                     bus.ready, bus.serial_out, bus.active_out);
        end

        // Idle, then a single word, then three back-to-back words.
        slot(1'b0, 8'h00, c_idle_pat,   1'b0, 1'b0, 8'h5A);
        slot(1'b1, 8'hA5, 8'b1010_0101, 1'b1, 1'b0, 8'h5A);
        slot(1'b1, 8'hFF, 8'b1111_1111, 1'b1, 1'b0, 8'h5A);
        slot(1'b1, 8'h00, 8'b0000_0000, 1'b1, 1'b0, 8'h5A);
        slot(1'b1, 8'h81, 8'b1000_0001, 1'b1, 1'b0, 8'h5A);

        // 0x3C offered only off the load phase is ignored, then accepted on the load.
        slot(1'b0, 8'h00, c_idle_pat,   1'b0, 1'b1, 8'h3C);
        slot(1'b1, 8'h3C, 8'b0011_1100, 1'b1, 1'b0, 8'h5A);

        // Reset after three bits of 0xA5: remainder must never appear.
        tick(1'b1, 1'b1, 8'hA5, 1'b1);
        offer(8'b1010_0101, 1'b1);
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 8'h5A, 1'b0);
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 8'h00, 1'b0);

        // Sixteen idle cycles after release: ready at cycles 0 and 8.
        slot(1'b0, 8'h00, c_idle_pat, 1'b0, 1'b0, 8'h00);
        slot(1'b0, 8'h00, c_idle_pat, 1'b0, 1'b0, 8'h00);
        tick(1'b1, 1'b0, 8'h00, 1'b1);

        @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, misc);
        if (misc == 0) $display("PASS");
        else           $display("FAIL");
        $finish;
    end

endmodule
`default_nettype wire
